instr_loader: RTL and testbench
===============================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter ADDR_W, default 10, instruction-memory address width; depth = 2**ADDR_W words.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 in_valid  input  1  byte-stream source has a byte on in_data.
REQ-005 in_data  input  8  program byte.
REQ-006 in_last  input  1  qualifies in_data as final byte of program; meaningful only with in_valid.
REQ-007 in_ready  output  1  loader accepts a byte this cycle.
REQ-008 mem_we  output  1  one-cycle write strobe to instruction memory.
REQ-009 mem_addr  output  ADDR_W  instruction-memory write address.
REQ-010 mem_wdata  output  18  instruction word to write.
REQ-011 cpu_run  output  1  releases the CPU to execute; stays high until reset.
REQ-012 word_count  output  ADDR_W+1  number of words written since reset.
REQ-013 error  output  1  sticky load-failure flag.

Function
REQ-014 A byte is accepted on a rising edge iff in_valid && in_ready; otherwise in_data/in_last are ignored and no state changes.
REQ-015 FSM states: LOAD_B0, LOAD_B1, LOAD_B2, WRITE, RUN, ERR; in_ready = 1 only in LOAD_B0/B1/B2.
REQ-016 Byte order big-endian: B0[1:0] -> word[17:16] (B0[7:2] ignored), B1 -> word[15:8], B2 -> word[7:0].
REQ-017 LOAD_B0 -> LOAD_B1 and LOAD_B1 -> LOAD_B2 on accept with in_last=0.
REQ-018 Accept with in_last=1 in LOAD_B0 or LOAD_B1 (partial word) -> ERR; no write occurs.
REQ-019 LOAD_B2 accept -> WRITE; in_last of that byte is registered as last_pending.
REQ-020 WRITE lasts exactly one cycle: mem_we=1, mem_addr=current address, mem_wdata=assembled word; address and word_count increment at end of cycle.
REQ-021 mem_we=1 in the cycle immediately after B2 is accepted (latency 1); mem_we=0 in all other states.
REQ-022 From WRITE: last_pending=1 -> RUN; else address just written = 2**ADDR_W-1 (memory full) -> ERR; else -> LOAD_B0.
REQ-023 Address never wraps; the overflow case of REQ-022 goes to ERR, not to address 0.
REQ-024 RUN and ERR are terminal until reset; input bytes are not accepted there.
REQ-025 cpu_run = 1 exactly when state is RUN; error = 1 exactly when state is ERR; never both.
REQ-026 mem_addr and mem_wdata hold their values outside WRITE; memory must only sample them with mem_we.

Reset
REQ-027 Reset, when high at a rising edge, overrides every other event including an in-flight accept or WRITE.
REQ-028 After reset: state LOAD_B0, in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, cpu_run=0, error=0, word_count=0, last_pending=0, partial bytes discarded.

Verification
REQ-029 Bytes 00,11,23 (last=0) then 02,12,0A (last=1), no gaps -> writes mem[0]=18'h01123, mem[1]=18'h2120A; cpu_run=1 one cycle after second mem_we; word_count=2; in_ready=0 afterwards.
REQ-030 Same stream with in_valid deasserted 3 cycles between every byte -> identical writes and final state; no mem_we during gaps.
REQ-031 Bytes 00,11 with in_last=1 on 11 -> error=1 next cycle, mem_we never asserted, cpu_run=0, in_ready=0.
REQ-032 ADDR_W=2: 4 words with last on word 4 -> cpu_run=1, word_count=4; 4 words without last -> error=1 after 4th write, mem_addr stays 3.
REQ-033 Reset asserted one cycle after B1 accepted, then stream 02,12,0A last=1 -> single write mem[0]=18'h2120A, word_count=1, cpu_run=1.
REQ-034 In RUN, drive in_valid=1 for 10 cycles -> in_ready=0, no mem_we, outputs unchanged; reset then returns all outputs to REQ-028 values.

Source files
------------

// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-memory write bundle for the instruction loader.
// The slave side is the loader; the master side is the byte source / memory / CPU.
interface instr_loader_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_last;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [17:0]       mem_wdata;
    logic              cpu_run;
    logic [ADDR_W:0]   word_count;
    logic              error;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_run, word_count, error
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_run, word_count, error
    );
endinterface

// File: rtl/instr_loader.sv
// Instruction loader: packs a big-endian byte stream into 18-bit instruction
// words (3 bytes each), writes them to consecutive memory addresses and then
// releases the CPU. A partial final word or a full memory is a sticky error.
module instr_loader #(
    parameter int ADDR_W = 10
) (
    input  logic          clk,
    input  logic          reset,
    instr_loader_if.slave bus
);
    typedef enum logic [2:0] {
        LOAD_B0 = 3'd0,
        LOAD_B1 = 3'd1,
        LOAD_B2 = 3'd2,
        WRITE   = 3'd3,
        RUN     = 3'd4,
        ERR     = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    state_t            state;
    logic [1:0]        b0_q;
    logic [7:0]        b1_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [17:0]       mem_wdata_q;
    logic [ADDR_W:0]   word_count_q;
    logic              last_pending;
    logic              in_ready_q;
    logic              mem_we_q;
    logic              cpu_run_q;
    logic              error_q;
    logic              accept;

    assign accept         = bus.in_valid && in_ready_q;
    assign bus.in_ready   = in_ready_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.cpu_run    = cpu_run_q;
    assign bus.word_count = word_count_q;
    assign bus.error      = error_q;

    // Load FSM with registered handshake, write strobe and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= LOAD_B0;
            b0_q         <= '0;
            b1_q         <= '0;
            addr_q       <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            word_count_q <= '0;
            last_pending <= 1'b0;
            in_ready_q   <= 1'b1;
            mem_we_q     <= 1'b0;
            cpu_run_q    <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            case (state)
                LOAD_B0: begin
                    if (accept) begin
                        b0_q <= bus.in_data[1:0];
                        if (bus.in_last) begin
                            state      <= ERR;
                            in_ready_q <= 1'b0;
                            error_q    <= 1'b1;
                        end else begin
                            state <= LOAD_B1;
                        end
                    end
                end
                LOAD_B1: begin
                    if (accept) begin
                        b1_q <= bus.in_data;
                        if (bus.in_last) begin
                            state      <= ERR;
                            in_ready_q <= 1'b0;
                            error_q    <= 1'b1;
                        end else begin
                            state <= LOAD_B2;
                        end
                    end
                end
                LOAD_B2: begin
                    // Word and address are presented together with the strobe
                    if (accept) begin
                        mem_wdata_q  <= {b0_q, b1_q, bus.in_data};
                        mem_addr_q   <= addr_q;
                        last_pending <= bus.in_last;
                        mem_we_q     <= 1'b1;
                        in_ready_q   <= 1'b0;
                        state        <= WRITE;
                    end
                end
                WRITE: begin
                    mem_we_q     <= 1'b0;
                    word_count_q <= word_count_q + 1'b1;
                    if (last_pending) begin
                        state     <= RUN;
                        cpu_run_q <= 1'b1;
                    end else if (addr_q == LAST_ADDR) begin
                        // Memory full: stop rather than wrap to address 0
                        state   <= ERR;
                        error_q <= 1'b1;
                    end else begin
                        addr_q     <= addr_q + 1'b1;
                        state      <= LOAD_B0;
                        in_ready_q <= 1'b1;
                    end
                end
                RUN, ERR: begin
                    // Terminal until reset
                end
                default: begin
                    state      <= ERR;
                    in_ready_q <= 1'b0;
                    mem_we_q   <= 1'b0;
                    cpu_run_q  <= 1'b0;
                    error_q    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: one instance at the default address width
// and one at ADDR_W=2 for the memory-full boundary.
module tb_instr_loader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    instr_loader_if #(.ADDR_W(10)) a_if ();
    instr_loader_if #(.ADDR_W(2))  b_if ();

    instr_loader #(.ADDR_W(10)) dut_a (.clk(clk), .reset(reset), .bus(a_if.slave));
    instr_loader #(.ADDR_W(2))  dut_b (.clk(clk), .reset(reset), .bus(b_if.slave));

    // Shared stimulus, steered to one instance by sel (0 = a, 1 = b)
    logic       sel = 1'b0;
    logic       in_valid_v = 1'b0;
    logic [7:0] in_data_v = '0;
    logic       in_last_v = 1'b0;

    assign a_if.in_valid = in_valid_v && !sel;
    assign a_if.in_data  = in_data_v;
    assign a_if.in_last  = in_last_v;
    assign b_if.in_valid = in_valid_v && sel;
    assign b_if.in_data  = in_data_v;
    assign b_if.in_last  = in_last_v;

    logic        ready_m, we_m, run_m, err_m;
    logic [31:0] addr_m, wdata_m, wc_m;

    always_comb begin
        ready_m = sel ? b_if.in_ready : a_if.in_ready;
        we_m    = sel ? b_if.mem_we   : a_if.mem_we;
        run_m   = sel ? b_if.cpu_run  : a_if.cpu_run;
        err_m   = sel ? b_if.error    : a_if.error;
        addr_m  = sel ? 32'(b_if.mem_addr)   : 32'(a_if.mem_addr);
        wdata_m = sel ? 32'(b_if.mem_wdata)  : 32'(a_if.mem_wdata);
        wc_m    = sel ? 32'(b_if.word_count) : 32'(a_if.word_count);
    end

    int n_checks = 0;
    int n_errors = 0;
    int exp_addr = 0;

    // Expected writes: [31:18] address, [17:0] word
    logic [31:0] q_a[$];
    logic [31:0] q_b[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Write monitors pop the scoreboard on every strobe
    always @(negedge clk) begin
        if (a_if.mem_we === 1'b1) begin
            if (q_a.size() == 0) chk("a_unexpected_we", 32'd1, 32'd0);
            else begin
                logic [31:0] e;
                e = q_a.pop_front();
                chk("a_wr_addr", 32'(a_if.mem_addr), 32'(e[31:18]));
                chk("a_wr_data", 32'(a_if.mem_wdata), 32'(e[17:0]));
            end
        end
    end

    always @(negedge clk) begin
        if (b_if.mem_we === 1'b1) begin
            if (q_b.size() == 0) chk("b_unexpected_we", 32'd1, 32'd0);
            else begin
                logic [31:0] e;
                e = q_b.pop_front();
                chk("b_wr_addr", 32'(b_if.mem_addr), 32'(e[31:18]));
                chk("b_wr_data", 32'(b_if.mem_wdata), 32'(e[17:0]));
            end
        end
    end

    always @(negedge clk) begin
        if (a_if.cpu_run && a_if.error) chk("a_run_and_err", 32'd1, 32'd0);
        if (b_if.cpu_run && b_if.error) chk("b_run_and_err", 32'd1, 32'd0);
    end

    task automatic do_reset();
        @(negedge clk);
        in_valid_v = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_addr = 0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ready"}, 32'(ready_m), 32'd1);
        chk({tag, "_we"}, 32'(we_m), 32'd0);
        chk({tag, "_addr"}, addr_m, 32'd0);
        chk({tag, "_wdata"}, wdata_m, 32'd0);
        chk({tag, "_run"}, 32'(run_m), 32'd0);
        chk({tag, "_err"}, 32'(err_m), 32'd0);
        chk({tag, "_wc"}, wc_m, 32'd0);
    endtask

    // Drive one byte from a negedge; returns at the negedge after acceptance
    task automatic send_byte(input logic [7:0] d, input logic last, input int gap);
        bit ok;
        ok = 1'b0;
        in_valid_v = 1'b1;
        in_data_v  = d;
        in_last_v  = last;
        for (int k = 0; k < 20; k++) begin
            if (ready_m) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
        if (gap > 0) begin
            in_valid_v = 1'b0;
            repeat (gap) begin
                chk("gap_no_we", 32'(we_m), 32'd0);
                @(negedge clk);
            end
        end
    endtask

    task automatic send_word(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z,
                             input logic last, input int gap);
        logic [31:0] e;
        e = {14'(exp_addr), x[1:0], y, z};
        if (sel) q_b.push_back(e);
        else     q_a.push_back(e);
        exp_addr++;
        send_byte(x, 1'b0, gap);
        send_byte(y, 1'b0, gap);
        send_byte(z, last, 0);
        chk("we_latency", 32'(we_m), 32'd1);
        if (gap > 0 || last) in_valid_v = 1'b0;
    endtask

    task automatic check_run(input string tag, input int wc);
        @(negedge clk);
        chk({tag, "_run"}, 32'(run_m), 32'd1);
        chk({tag, "_err"}, 32'(err_m), 32'd0);
        chk({tag, "_wc"}, wc_m, 32'(wc));
        chk({tag, "_ready"}, 32'(ready_m), 32'd0);
        chk({tag, "_we"}, 32'(we_m), 32'd0);
    endtask

    initial begin
        // Reset state
        sel = 1'b0;
        do_reset();
        check_reset_state("rst_a");

        // Two-word program, no gaps
        send_word(8'h00, 8'h11, 8'h23, 1'b0, 0);
        send_word(8'h02, 8'h12, 8'h0A, 1'b1, 0);
        check_run("nogap", 2);

        // Bytes offered in RUN are ignored and outputs hold
        in_valid_v = 1'b1;
        in_data_v  = 8'h3C;
        in_last_v  = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("run_ready", 32'(ready_m), 32'd0);
            chk("run_we", 32'(we_m), 32'd0);
        end
        chk("run_hold_run", 32'(run_m), 32'd1);
        chk("run_hold_addr", addr_m, 32'd1);
        chk("run_hold_wdata", wdata_m, 32'h2120A);
        chk("run_hold_wc", wc_m, 32'd2);
        do_reset();
        check_reset_state("rst_run");

        // Same program with 3-cycle gaps between bytes
        send_word(8'h00, 8'h11, 8'h23, 1'b0, 3);
        send_word(8'h02, 8'h12, 8'h0A, 1'b1, 3);
        check_run("gap", 2);

        // Partial word: last on second byte
        do_reset();
        send_byte(8'h00, 1'b0, 0);
        send_byte(8'h11, 1'b1, 0);
        in_valid_v = 1'b0;
        chk("partial_err", 32'(err_m), 32'd1);
        chk("partial_run", 32'(run_m), 32'd0);
        chk("partial_ready", 32'(ready_m), 32'd0);
        chk("partial_wc", wc_m, 32'd0);
        repeat (3) @(negedge clk);

        // Reset one cycle after B1, colliding with an offered B2
        do_reset();
        send_byte(8'h00, 1'b0, 0);
        send_byte(8'h11, 1'b0, 0);
        in_data_v = 8'h23;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        in_valid_v = 1'b0;
        exp_addr = 0;
        check_reset_state("rst_mid");
        send_word(8'h02, 8'h12, 8'h0A, 1'b1, 0);
        check_run("after_rst", 1);

        // Small memory: program fills it exactly
        sel = 1'b1;
        do_reset();
        check_reset_state("rst_b");
        send_word(8'h01, 8'hA0, 8'h01, 1'b0, 0);
        send_word(8'h02, 8'hB0, 8'h02, 1'b0, 0);
        send_word(8'h03, 8'hC0, 8'h03, 1'b0, 0);
        send_word(8'hFF, 8'hD0, 8'h04, 1'b1, 0);
        check_run("full_last", 4);

        // Small memory: overflow without last
        do_reset();
        send_word(8'h01, 8'h11, 8'h21, 1'b0, 0);
        send_word(8'h02, 8'h12, 8'h22, 1'b0, 0);
        send_word(8'h03, 8'h13, 8'h23, 1'b0, 0);
        send_word(8'h00, 8'h14, 8'h24, 1'b0, 0);
        in_valid_v = 1'b1;
        @(negedge clk);
        chk("ovf_err", 32'(err_m), 32'd1);
        chk("ovf_run", 32'(run_m), 32'd0);
        chk("ovf_addr", addr_m, 32'd3);
        chk("ovf_wc", wc_m, 32'd4);
        chk("ovf_ready", 32'(ready_m), 32'd0);
        repeat (5) @(negedge clk);
        chk("ovf_hold_addr", addr_m, 32'd3);
        in_valid_v = 1'b0;

        chk("q_a_empty", 32'(q_a.size()), 32'd0);
        chk("q_b_empty", 32'(q_b.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=%0d", 0, 1);
        $fatal(1, "timeout");
    end
endmodule
